// File: rtl/mobo_mem_port_pkg.sv
// rtl/mobo_mem_port_pkg.sv - mobo control/status field layout and memory port state encodings
package mobo_mem_port_pkg;

  localparam int MOBO_WORD_WIDTH = 16;

  localparam int MOBO_REQ_BIT = 0;
  localparam int MOBO_CMD_LSB = 1;
  localparam int MOBO_CMD_MSB = 2;

  localparam int MOBO_STAT_BUSY = 0;
  localparam int MOBO_STAT_DONE = 1;
  localparam int MOBO_STAT_ERR  = 2;

  typedef enum logic [1:0] {
    MOBO_CMD_NONE  = 2'b00,
    MOBO_CMD_READ  = 2'b01,
    MOBO_CMD_WRITE = 2'b10,
    MOBO_CMD_RSVD  = 2'b11
  } mobo_cmd_t;

  typedef enum logic [1:0] {
    MOBO_PORT_IDLE   = 2'd0,
    MOBO_PORT_WAIT   = 2'd1,
    MOBO_PORT_ACCESS = 2'd2,
    MOBO_PORT_DONE   = 2'd3
  } mobo_port_state_t;

endpackage

// File: rtl/mobo_ram.sv
// rtl/mobo_ram.sv - single-port word-addressed RAM, registered read, contents survive reset
module mobo_ram #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_WIDTH-1:0]    wdata,
  output logic [WORD_WIDTH-1:0]    rdata
);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/mobo_mem_port.sv
// rtl/mobo_mem_port.sv - cpu-facing memory port: 4-phase req/done handshake in front of mobo_ram
// with a programmable number of wait states.
module mobo_mem_port
  import mobo_mem_port_pkg::*;
#(
  parameter int WORD_WIDTH  = MOBO_WORD_WIDTH,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] mobo_ctrl,
  input  logic [WORD_WIDTH-1:0] addr_in,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] mobo_stat,
  output logic [WORD_WIDTH-1:0] data_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mobo_port_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  mobo_cmd_t             r_cmd, w_cmd_in;
  logic [IDX_W-1:0]      r_addr, w_ram_idx;
  logic [WORD_WIDTH-1:0] r_data, r_data_out, r_stat, w_stat_nxt, w_rdata;
  logic                  w_req, w_cmd_ok, w_addr_ok, w_err_nxt, w_latch, w_ram_we;
  logic                  w_unused_ctrl;

  assign w_req         = mobo_ctrl[MOBO_REQ_BIT];
  assign w_cmd_in      = mobo_cmd_t'(mobo_ctrl[MOBO_CMD_MSB:MOBO_CMD_LSB]);
  assign w_unused_ctrl = ^mobo_ctrl[WORD_WIDTH-1:MOBO_CMD_MSB+1];
  assign w_cmd_ok      = (w_cmd_in == MOBO_CMD_READ) || (w_cmd_in == MOBO_CMD_WRITE);
  // Full-width compare so aliases above DEPTH are rejected, not wrapped.
  assign w_addr_ok     = {1'b0, addr_in} < (WORD_WIDTH + 1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= MOBO_PORT_IDLE;
      r_cnt      <= '0;
      r_cmd      <= MOBO_CMD_NONE;
      r_addr     <= '0;
      r_data     <= '0;
      r_stat     <= '0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stat  <= w_stat_nxt;
      if (w_latch) begin
        r_cmd  <= w_cmd_in;
        r_addr <= addr_in[IDX_W-1:0];
        r_data <= data_in;
      end
      if (r_state == MOBO_PORT_ACCESS && r_cmd == MOBO_CMD_READ) begin
        r_data_out <= w_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      MOBO_PORT_IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (!w_cmd_ok || !w_addr_ok) begin
            w_state_nxt = MOBO_PORT_DONE;
            w_err_nxt   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            w_state_nxt = MOBO_PORT_ACCESS;
          end else begin
            w_state_nxt = MOBO_PORT_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      MOBO_PORT_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = MOBO_PORT_ACCESS;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      MOBO_PORT_ACCESS: w_state_nxt = MOBO_PORT_DONE;
      MOBO_PORT_DONE: begin
        w_err_nxt = r_stat[MOBO_STAT_ERR];
        if (!w_req) begin
          w_state_nxt = MOBO_PORT_IDLE;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = MOBO_PORT_IDLE;
    endcase
  end

  // In IDLE the RAM is addressed straight from addr_in so a zero-wait read has data ready in ACCESS.
  always_comb begin
    w_stat_nxt                 = '0;
    w_stat_nxt[MOBO_STAT_BUSY] = (w_state_nxt == MOBO_PORT_WAIT) || (w_state_nxt == MOBO_PORT_ACCESS);
    w_stat_nxt[MOBO_STAT_DONE] = (w_state_nxt == MOBO_PORT_DONE);
    w_stat_nxt[MOBO_STAT_ERR]  = (w_state_nxt == MOBO_PORT_DONE) && w_err_nxt;
    w_ram_we                   = rst && (r_state == MOBO_PORT_ACCESS) && (r_cmd == MOBO_CMD_WRITE);
    w_ram_idx                  = (r_state == MOBO_PORT_IDLE) ? addr_in[IDX_W-1:0] : r_addr;
  end

  mobo_ram #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .idx   (w_ram_idx),
    .wdata (r_data),
    .rdata (w_rdata)
  );

  assign mobo_stat = r_stat;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_mobo_mem_port.sv
// tb/tb_mobo_mem_port.sv - scoreboard bench driving a 2-wait and a 0-wait port with identical traffic
module tb_mobo_mem_port;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] mobo_ctrl = '0;
  logic [W-1:0] addr_in = '0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] stat2, dout2, stat0, dout0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic         err;
    logic         chk_data;
    logic [W-1:0] data;
    int           lat;
    int           busy;
  } exp_t;

  exp_t q_w2[$];
  exp_t q_w0[$];

  logic [W-1:0] m_mem [256];
  bit           m_known [256];
  logic [W-1:0] m_last = '0;
  bit           m_last_known = 1'b1;

  always #5 clk = ~clk;

  mobo_mem_port #(.WORD_WIDTH(W), .DEPTH(256), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .mobo_ctrl(mobo_ctrl), .addr_in(addr_in), .data_in(data_in),
    .mobo_stat(stat2), .data_out(dout2)
  );

  mobo_mem_port #(.WORD_WIDTH(W), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .mobo_ctrl(mobo_ctrl), .addr_in(addr_in), .data_in(data_in),
    .mobo_stat(stat0), .data_out(dout0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_done(input string tag, input exp_t e, input int k, input int busy,
                            input logic [W-1:0] stat, input logic [W-1:0] dout);
    chk({tag, "_lat"}, k, e.lat);
    chk({tag, "_err"}, {31'b0, stat[2]}, {31'b0, e.err});
    chk({tag, "_busy"}, busy, e.busy);
    if (e.chk_data) chk({tag, "_data"}, {16'b0, dout}, {16'b0, e.data});
  endtask

  task automatic txn(input string tag, input logic [1:0] cmd, input logic [W-1:0] addr,
                     input logic [W-1:0] data, input int hold, input bit chg);
    exp_t e;
    bit   is_rd, is_wr, err, seen2, seen0;
    int   busy2, busy0;
    is_rd = (cmd == 2'b01);
    is_wr = (cmd == 2'b10);
    err   = !(is_rd || is_wr) || (addr >= 256);
    e.err = err;
    if (is_rd && !err) begin
      e.chk_data   = m_known[addr[7:0]];
      e.data       = m_mem[addr[7:0]];
      m_last       = m_mem[addr[7:0]];
      m_last_known = m_known[addr[7:0]];
    end else begin
      e.chk_data = m_last_known;
      e.data     = m_last;
    end
    if (is_wr && !err) begin
      m_mem[addr[7:0]]   = data;
      m_known[addr[7:0]] = 1'b1;
    end
    e.lat  = err ? 1 : 4;
    e.busy = err ? 0 : 3;
    q_w2.push_back(e);
    e.lat  = err ? 1 : 2;
    e.busy = err ? 0 : 1;
    q_w0.push_back(e);

    @(negedge clk);
    mobo_ctrl = {13'b0, cmd, 1'b1};
    addr_in   = addr;
    data_in   = data;
    seen2 = 0; seen0 = 0; busy2 = 0; busy0 = 0;
    for (int k = 1; k <= 20 && !(seen2 && seen0); k++) begin
      @(posedge clk);
      #1;
      if (!seen2 && stat2[0]) busy2++;
      if (!seen0 && stat0[0]) busy0++;
      if (!seen2 && stat2[1]) begin
        seen2 = 1;
        check_done({tag, "_w2"}, q_w2.pop_front(), k, busy2, stat2, dout2);
      end
      if (!seen0 && stat0[1]) begin
        seen0 = 1;
        check_done({tag, "_w0"}, q_w0.pop_front(), k, busy0, stat0, dout0);
      end
      if (chg && k == 1) begin
        addr_in = addr + 16'd1;
        data_in = ~data;
      end
    end
    if (!seen2) begin
      chk({tag, "_w2_timeout"}, 0, 1);
      void'(q_w2.pop_front());
    end
    if (!seen0) begin
      chk({tag, "_w0_timeout"}, 0, 1);
      void'(q_w0.pop_front());
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_w2"}, {29'b0, stat2[2:0]}, {29'b0, err, 2'b10});
      chk({tag, "_hold_w0"}, {29'b0, stat0[2:0]}, {29'b0, err, 2'b10});
    end
    @(negedge clk);
    mobo_ctrl = '0;
    @(posedge clk);
    #1;
    chk({tag, "_rel_w2"}, {16'b0, stat2}, 32'h0);
    chk({tag, "_rel_w0"}, {16'b0, stat0}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stat_w2", {16'b0, stat2}, 32'h0);
    chk("rst_dout_w2", {16'b0, dout2}, 32'h0);
    chk("rst_stat_w0", {16'b0, stat0}, 32'h0);
    chk("rst_dout_w0", {16'b0, dout0}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    txn("wr3",    2'b10, 16'd3,   16'h00A5, 0, 0);
    txn("rd3",    2'b01, 16'd3,   16'h0000, 0, 0);
    txn("wr0",    2'b10, 16'd0,   16'h1234, 0, 0);
    txn("rd0",    2'b01, 16'd0,   16'h0000, 0, 0);
    txn("rd256",  2'b01, 16'd256, 16'h0000, 0, 0);
    txn("wr44",   2'b10, 16'd44,  16'h4444, 0, 0);
    txn("wr300",  2'b10, 16'd300, 16'hBEEF, 0, 0);
    txn("rd44",   2'b01, 16'd44,  16'h0000, 0, 0);
    txn("cmd11",  2'b11, 16'd5,   16'h0000, 5, 0);
    txn("cmd00",  2'b00, 16'd5,   16'h0000, 0, 0);
    txn("wr8",    2'b10, 16'd8,   16'h8888, 0, 0);
    txn("wr7chg", 2'b10, 16'd7,   16'h0F0F, 0, 1);
    txn("rd7",    2'b01, 16'd7,   16'h0000, 0, 0);
    txn("rd8",    2'b01, 16'd8,   16'h0000, 0, 0);

    @(negedge clk);
    mobo_ctrl = 16'h0005;
    addr_in   = 16'd4;
    data_in   = 16'h0055;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_stat_w2", {16'b0, stat2}, 32'h0);
    chk("midrst_dout_w2", {16'b0, dout2}, 32'h0);
    chk("midrst_stat_w0", {16'b0, stat0}, 32'h0);
    chk("midrst_dout_w0", {16'b0, dout0}, 32'h0);
    @(negedge clk);
    rst          = 1'b1;
    mobo_ctrl    = '0;
    m_last       = '0;
    m_last_known = 1'b1;

    txn("rd4", 2'b01, 16'd4, 16'h0000, 0, 0);
    chk("rd4_not55_w2", {31'b0, dout2 != 16'h0055}, 32'h1);
    chk("rd4_not55_w0", {31'b0, dout0 != 16'h0055}, 32'h1);
    txn("rd3_kept", 2'b01, 16'd3, 16'h0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mobo_mem_port.md
Name: mobo_mem_port

Overview:
Motherboard-side memory port, directly downstream of the cpu core. It consumes the cpu's mobo_ctrl command word, address register output and outgoing data register output. It returns mobo_stat and the incoming data word over a 4-phase req/done handshake. It fronts a single-port word-addressed RAM with a programmable number of wait states.

Parameters:
WORD_WIDTH, `WORD_WIDTH, width of address, data, ctrl and stat words
DEPTH, 256, number of RAM words; valid addresses 0..DEPTH-1
WAIT_CYCLES, 2, wait states inserted before each access (0 allowed)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset rst, synchronous, active-low; clock clk
mobo_ctrl  in  WORD_WIDTH  [0]=req, [2:1]=cmd (00 none, 01 read, 10 write, 11 reserved), rest ignored
addr_in  in  WORD_WIDTH  word address (from cpu address register)
data_in  in  WORD_WIDTH  write data (from cpu outgoing data register)
mobo_stat  out  WORD_WIDTH  [0]=busy, [1]=done, [2]=err, rest 0
data_out  out  WORD_WIDTH  read data (to cpu incoming data register)

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, wait counter=0, mobo_stat=0, data_out=0, latched addr/data/cmd=0. RAM contents are not cleared. Reset wins over every other event, including mid-access; an interrupted write has no effect.
- States: IDLE, WAIT, ACCESS, DONE. mobo_stat is a registered decode: busy=1 in WAIT/ACCESS; done=1 in DONE; err held valid only in DONE.
- IDLE: on posedge with req=1, latch addr_in, data_in and cmd. Later changes on these inputs are ignored until the next IDLE.
  - cmd 00 or 11: go to DONE with err=1; no RAM access.
  - addr_in >= DEPTH: go to DONE with err=1; no RAM access. A read leaves data_out unchanged.
  - Otherwise: if WAIT_CYCLES=0 go to ACCESS; else go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: if counter==0 go to ACCESS, else decrement. req is not sampled here. Dropping req early does not abort the access.
- ACCESS: exactly one cycle.
  - Read: data_out <= RAM[addr] (registered, visible at the same edge done rises).
  - Write: RAM[addr] <= data. data_out unchanged.
  - Next state is DONE with err=0.
- DONE: done=1 held. When req==0 is sampled, go to IDLE; done/err clear at that edge. If req is still 1, stay (4-phase handshake). A new request requires req to return to 0 first.
- Latency: done is visible WAIT_CYCLES+2 posedges after the edge that sampled req in IDLE. Error path: 1 edge.
- data_out holds the last successful read value until the next successful read or reset.
- Address compare is on the full WORD_WIDTH value. RAM index uses the low clog2(DEPTH) bits.
- Back-to-back: the minimum full transaction is WAIT_CYCLES+3 cycles (DONE→IDLE costs 1 edge).

Decomposition:
- Shared defines file (alongside the existing mobo state defines):
  - MOBO_REQ_BIT, MOBO_CMD_LSB/MSB
  - MOBO_CMD_NONE/READ/WRITE
  - MOBO_STAT_BUSY/DONE/ERR bit indices
  - MOBO_PORT_IDLE/WAIT/ACCESS/DONE state encodings
  These are consumed by cpu_fcn_rw and this block alike.
- Sub-module mobo_ram: single-port synchronous RAM with params WORD_WIDTH and DEPTH; ports clk, we, idx, wdata, rdata (registered read, no reset). mobo_mem_port holds the FSM, counter and latches only.

Test Plan:
- Reset mid-op: apply rst=0 during WAIT of a write of 0x0055 to addr 4 -> next edge state IDLE, mobo_stat=0, data_out=0. A later read of addr 4 does not return 0x0055.
- Write then read, WAIT_CYCLES=2: write 0x00A5 to addr 3 -> done rises exactly 4 edges after sampling req, err=0. Drop req -> done clears 1 edge later. Read addr 3 -> data_out=0x00A5 at the edge done rises.
- Zero wait states: WAIT_CYCLES=0, read addr 0 after writing 0x1234 -> done 2 edges after req sample. Busy high for exactly 1 cycle.
- Out of range: read addr DEPTH (256) -> done+err 1 edge after sample, busy never set, data_out keeps previous value. Write addr 300 -> err=1, RAM unchanged.
- Bad command: req=1 with cmd=11 -> done=1, err=1 next edge. Holding req=1 for 5 cycles keeps done=1. Release -> IDLE.
- Input stability: change addr_in/data_in during WAIT of a write of 0x0F0F to addr 7 -> addr 7 reads back 0x0F0F, the new address is untouched.
